// File: rtl/sg_pkg.sv
// Shared definitions for the signal generator register-write path:
// word geometry, register map and the serial receiver state type.
package sg_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 5;
    localparam int WORD_W = 8;

    localparam logic [ADDR_W-1:0] REG_PERIOD_A = 3'd0;
    localparam logic [ADDR_W-1:0] REG_PERIOD_B = 3'd1;
    localparam logic [ADDR_W-1:0] REG_VOL_A    = 3'd2;
    localparam logic [ADDR_W-1:0] REG_VOL_B    = 3'd3;
    localparam logic [ADDR_W-1:0] REG_VOL_N    = 3'd4;
    localparam logic [ADDR_W-1:0] REG_ENABLE   = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ERR_WAIT
    } rx_state_t;

    // A received word carries the register address in its top bits.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [WORD_W-1:0] word);
        return word[WORD_W-1:DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] word_data(input logic [WORD_W-1:0] word);
        return word[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/sync_edge.sv
// N-stage synchronizer for a slow external pin, with an optional registered
// rising-edge pulse aligned to the registered level output.
module sync_edge #(
    parameter int STAGES    = 2,
    parameter bit RESET_VAL = 1'b0,
    parameter bit EDGE_EN   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] chain;

    // level is the synchronized value delayed one more flop, so it doubles
    // as the previous value for edge detection and stays aligned with rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
            level <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            level <= chain[STAGES-1];
        end
    end

    generate
        if (EDGE_EN) begin : g_edge
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rise <= 1'b0;
                end else begin
                    rise <= chain[STAGES-1] & ~level;
                end
            end
        end else begin : g_no_edge
            assign rise = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/cmd_deserializer.sv
// Serial front end: deserializes 8-bit register-write words from three slow
// pins into one-cycle address/data writes, dropping malformed frames.
module cmd_deserializer
    import sg_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_clk,
    input  logic              ser_data,
    input  logic              ser_cs_n,
    output logic              write_strobe,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              frame_err,
    output logic              busy
);

    localparam logic [11:0] TIMEOUT_LAST = 12'(TIMEOUT_CYCLES - 1);

    logic s_clk_unused;
    logic s_rise;
    logic s_data;
    logic data_rise_unused;
    logic s_cs_n;
    logic cs_rise_unused;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b1)) u_sync_clk (
        .clk   (clk),
        .rst   (rst),
        .din   (ser_clk),
        .level (s_clk_unused),
        .rise  (s_rise)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b0)) u_sync_data (
        .clk   (clk),
        .rst   (rst),
        .din   (ser_data),
        .level (s_data),
        .rise  (data_rise_unused)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1), .EDGE_EN(1'b0)) u_sync_cs (
        .clk   (clk),
        .rst   (rst),
        .din   (ser_cs_n),
        .level (s_cs_n),
        .rise  (cs_rise_unused)
    );

    rx_state_t         state, state_next;
    logic [2:0]        bit_cnt, bit_cnt_next;
    logic [WORD_W-1:0] shift_reg, shift_next;
    logic [WORD_W-1:0] word_next;
    logic [11:0]       timer, timer_next;
    logic              strobe_next;
    logic              err_next;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] data_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            timer        <= '0;
            write_strobe <= 1'b0;
            frame_err    <= 1'b0;
            address      <= '0;
            data         <= '0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            bit_cnt      <= bit_cnt_next;
            shift_reg    <= shift_next;
            timer        <= timer_next;
            write_strobe <= strobe_next;
            frame_err    <= err_next;
            address      <= addr_next;
            data         <= data_next;
            busy         <= (bit_cnt_next != 3'd0);
        end
    end

    // Chip-select release outranks a coincident edge, and an edge outranks
    // a coincident timeout, so the branches below are ordered accordingly.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift_reg;
        word_next    = {shift_reg[WORD_W-2:0], s_data};
        timer_next   = timer;
        strobe_next  = 1'b0;
        err_next     = 1'b0;
        addr_next    = address;
        data_next    = data;

        case (state)
            IDLE: begin
                bit_cnt_next = '0;
                timer_next   = '0;
                if (!s_cs_n) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (s_cs_n) begin
                    err_next     = (bit_cnt != 3'd0);
                    bit_cnt_next = '0;
                    shift_next   = '0;
                    state_next   = IDLE;
                end else if (s_rise) begin
                    shift_next = word_next;
                    timer_next = '0;
                    if (bit_cnt == 3'd7) begin
                        strobe_next  = 1'b1;
                        addr_next    = word_addr(word_next);
                        data_next    = word_data(word_next);
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end else if (bit_cnt != 3'd0) begin
                    if (timer == TIMEOUT_LAST) begin
                        err_next     = 1'b1;
                        bit_cnt_next = '0;
                        shift_next   = '0;
                        timer_next   = '0;
                        state_next   = ERR_WAIT;
                    end else begin
                        timer_next = timer + 12'd1;
                    end
                end
            end
            ERR_WAIT: begin
                bit_cnt_next = '0;
                timer_next   = '0;
                if (s_cs_n) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cmd_deserializer.sv
// Self-checking bench for cmd_deserializer: table of whole frames, directed
// corner sequences and random frames checked against a word-level model.
module tb_cmd_deserializer;

    localparam int S  = 2;
    localparam int TO = 300;

    logic       clk = 1'b0;
    logic       rst;
    logic       ser_clk;
    logic       ser_data;
    logic       ser_cs_n;
    logic       write_strobe;
    logic [2:0] address;
    logic [4:0] data;
    logic       frame_err;
    logic       busy;

    cmd_deserializer #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .ser_clk      (ser_clk),
        .ser_data     (ser_data),
        .ser_cs_n     (ser_cs_n),
        .write_strobe (write_strobe),
        .address      (address),
        .data         (data),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int err_cnt = 0;
    int last_strobe_cyc = 0;
    int last_rise_cyc = 0;
    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (write_strobe) begin
                strobe_cnt++;
                obs_q.push_back({address, data});
                last_strobe_cyc = cyc;
            end
            if (frame_err) err_cnt++;
        end
    end

    typedef struct {
        logic [7:0] word;
        int         nbits;
        int         exp_strobes;
        int         exp_errs;
        logic [2:0] exp_addr;
        logic [4:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_mis++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendBit(input logic b, input int lo, input int hi);
        ser_data = b;
        waitCycles(lo);
        ser_clk = 1'b1;
        last_rise_cyc = cyc;
        waitCycles(hi);
        ser_clk = 1'b0;
    endtask

    task automatic sendBits(input logic [7:0] word, input int n, input int lo, input int hi);
        for (int i = 0; i < n; i++) sendBit(word[7-i], lo, hi);
    endtask

    task automatic applyStimulus(input logic [7:0] word, input int nbits);
        ser_cs_n = 1'b0;
        waitCycles(2);
        sendBits(word, nbits, 3, 3);
        waitCycles(3);
        ser_cs_n = 1'b1;
        waitCycles(8);
    endtask

    initial begin
        int s0, e0;
        rst = 1'b1;
        ser_clk = 1'b0;
        ser_data = 1'b0;
        ser_cs_n = 1'b1;

        vecs[0] = '{8'hA7, 8, 1, 0, 3'd5, 5'd7};
        vecs[1] = '{8'hB8, 5, 0, 1, 3'd5, 5'd7};
        vecs[2] = '{8'h9F, 8, 1, 0, 3'd4, 5'd31};
        vecs[3] = '{8'hFF, 8, 1, 0, 3'd7, 5'd31};
        vecs[4] = '{8'hC0, 8, 1, 0, 3'd6, 5'd0};
        vecs[5] = '{8'h00, 1, 0, 1, 3'd6, 5'd0};
        vecs[6] = '{8'h00, 0, 0, 0, 3'd6, 5'd0};
        vecs[7] = '{8'h21, 8, 1, 0, 3'd1, 5'd1};

        waitCycles(3);
        checkOutput("reset_strobe", 32'(write_strobe), 0);
        checkOutput("reset_addr", 32'(address), 0);
        checkOutput("reset_data", 32'(data), 0);
        checkOutput("reset_err", 32'(frame_err), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        rst = 1'b0;
        waitCycles(3);

        for (int v = 0; v < 8; v++) begin
            s0 = strobe_cnt;
            e0 = err_cnt;
            applyStimulus(vecs[v].word, vecs[v].nbits);
            checkOutput($sformatf("vec%0d_strobes", v), 32'(strobe_cnt - s0), 32'(vecs[v].exp_strobes));
            checkOutput($sformatf("vec%0d_errs", v), 32'(err_cnt - e0), 32'(vecs[v].exp_errs));
            checkOutput($sformatf("vec%0d_addr", v), 32'(address), 32'(vecs[v].exp_addr));
            checkOutput($sformatf("vec%0d_data", v), 32'(data), 32'(vecs[v].exp_data));
            checkOutput($sformatf("vec%0d_busy", v), 32'(busy), 0);
            if (vecs[v].exp_strobes == 1)
                checkOutput($sformatf("vec%0d_latency", v), 32'(last_strobe_cyc - last_rise_cyc), 32'(S + 2));
        end

        // Two words in one frame.
        obs_q.delete();
        s0 = strobe_cnt;
        ser_cs_n = 1'b0;
        waitCycles(2);
        sendBits(8'h03, 8, 3, 3);
        sendBits(8'h4C, 8, 3, 3);
        waitCycles(3);
        ser_cs_n = 1'b1;
        waitCycles(8);
        checkOutput("b2b_strobes", 32'(strobe_cnt - s0), 2);
        if (obs_q.size() == 2) begin
            checkOutput("b2b_word0", 32'(obs_q[0]), 32'h03);
            checkOutput("b2b_word1", 32'(obs_q[1]), 32'h4C);
        end else begin
            checkOutput("b2b_queue", 32'(obs_q.size()), 2);
        end
        checkOutput("b2b_hold_addr", 32'(address), 2);
        checkOutput("b2b_hold_data", 32'(data), 12);

        // 8th edge and chip-select release land in the same cycle.
        s0 = strobe_cnt;
        e0 = err_cnt;
        ser_cs_n = 1'b0;
        waitCycles(2);
        sendBits(8'hE5, 7, 3, 3);
        ser_data = 1'b1;
        waitCycles(3);
        ser_clk = 1'b1;
        ser_cs_n = 1'b1;
        waitCycles(3);
        ser_clk = 1'b0;
        waitCycles(8);
        checkOutput("simul_errs", 32'(err_cnt - e0), 1);
        checkOutput("simul_strobes", 32'(strobe_cnt - s0), 0);
        checkOutput("simul_addr", 32'(address), 2);
        checkOutput("simul_data", 32'(data), 12);

        // Stalled serial clock.
        s0 = strobe_cnt;
        e0 = err_cnt;
        ser_cs_n = 1'b0;
        waitCycles(2);
        sendBits(8'hA0, 3, 3, 3);
        waitCycles(5);
        checkOutput("stall_busy_mid", 32'(busy), 1);
        waitCycles(TO + 10);
        checkOutput("stall_errs", 32'(err_cnt - e0), 1);
        checkOutput("stall_busy_after", 32'(busy), 0);
        sendBits(8'hFF, 8, 3, 3);
        waitCycles(5);
        checkOutput("stall_ignored_errs", 32'(err_cnt - e0), 1);
        checkOutput("stall_ignored_strobes", 32'(strobe_cnt - s0), 0);
        ser_cs_n = 1'b1;
        waitCycles(8);
        applyStimulus(8'h5A, 8);
        checkOutput("stall_next_strobes", 32'(strobe_cnt - s0), 1);
        checkOutput("stall_next_addr", 32'(address), 2);
        checkOutput("stall_next_data", 32'(data), 26);

        // Reset in the middle of a word.
        e0 = err_cnt;
        ser_cs_n = 1'b0;
        waitCycles(2);
        sendBits(8'hF0, 4, 3, 3);
        waitCycles(2);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_addr", 32'(address), 0);
        checkOutput("rst_mid_data", 32'(data), 0);
        checkOutput("rst_mid_busy", 32'(busy), 0);
        checkOutput("rst_mid_err", 32'(frame_err), 0);
        checkOutput("rst_mid_strobe", 32'(write_strobe), 0);
        ser_cs_n = 1'b1;
        waitCycles(3);
        rst = 1'b0;
        waitCycles(5);
        checkOutput("rst_no_err", 32'(err_cnt - e0), 0);
        applyStimulus(8'h21, 8);
        checkOutput("rst_next_addr", 32'(address), 1);
        checkOutput("rst_next_data", 32'(data), 1);

        // Random frames against a word-level model.
        for (int f = 0; f < 40; f++) begin
            int nwords, trunc, lo, hi;
            logic [7:0] w, last_w, got;
            nwords = $urandom_range(1, 3);
            trunc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            lo = $urandom_range(3, 6);
            hi = $urandom_range(3, 6);
            obs_q.delete();
            exp_q.delete();
            s0 = strobe_cnt;
            e0 = err_cnt;
            last_w = {address, data};
            ser_cs_n = 1'b0;
            waitCycles($urandom_range(1, 4));
            for (int k = 0; k < nwords; k++) begin
                w = 8'($urandom);
                exp_q.push_back(w);
                last_w = w;
                sendBits(w, 8, lo, hi);
            end
            if (trunc != 0) sendBits(8'($urandom), trunc, lo, hi);
            waitCycles(lo);
            ser_cs_n = 1'b1;
            waitCycles(8 + $urandom_range(0, 5));
            checkOutput($sformatf("rnd%0d_strobes", f), 32'(strobe_cnt - s0), 32'(nwords));
            checkOutput($sformatf("rnd%0d_errs", f), 32'(err_cnt - e0), 32'(trunc != 0));
            while (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                got = (obs_q.size() > 0) ? obs_q.pop_front() : ~w;
                checkOutput($sformatf("rnd%0d_word", f), 32'(got), 32'(w));
            end
            checkOutput($sformatf("rnd%0d_hold", f), 32'({address, data}), 32'(last_w));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
